udp_multiport_parser: RTL and testbench
=======================================

# udp_multiport_parser

Byte-stream UDP parser with a parametrised table of target ports, per-packet channel tagging, optional checksum verification, and packet/drop statistics. It is the next-generation front end of the UDP receive path, between the IP-layer byte stream and the per-application payload consumers. Matched payloads are forwarded with a channel index. Non-matching and malformed packets are consumed and discarded.

## Interface
- NUM_PORTS, 4, number of target-port table entries (≥1); CHAN_W = max(1, $clog2(NUM_PORTS))
- CNT_W, 16, width of the statistics counters and the cycle counter
- CSUM_EN, 1, 1 = verify UDP checksum; 0 = payload_err is tied to 0
- clk  in  1  single clock; all logic is rising-edge
- rst  in  1  asynchronous, active-high reset
- target_ports  in  NUM_PORTS*16  entry i occupies bits [16i+15:16i]
- port_en  in  NUM_PORTS  per-entry enable
- pseudo_sum  in  16  IP pseudo-header ones'-complement sum, sampled with the first header byte
- data_in  in  8  input byte
- data_valid_in  in  1  input byte valid
- ready_out  out  1  input ready; a byte transfers when data_valid_in && ready_out
- payload_data_out  out  8  forwarded payload byte
- payload_valid_out  out  1  payload byte valid
- payload_last  out  1  final payload byte of the packet
- payload_chan  out  CHAN_W  matched table index, stable for the whole packet
- payload_err  out  1  checksum failure, valid only with payload_last
- ready_in  in  1  downstream ready
- src_port, dst_port, length  out  16 each  header fields, latched at header end
- header_done  out  1  one-cycle pulse after the 8th header byte
- drop_pulse  out  1  one-cycle pulse when a packet is classified as dropped
- pkt_count, drop_count  out  CNT_W  forwarded and dropped packet totals
- latched_cycle_count  out  CNT_W  duration of the last completed packet

## Operation
- Header bytes are big-endian: src[15:8], src[7:0], dst, length, checksum (bytes 0–7). `length` includes the 8-byte header.
- FSM states: IDLE, HDR, FWD, DROP.
  - IDLE → HDR on the first accepted byte, which counts as byte 0.
  - HDR accepts bytes 1–7.
  - After byte 7 is accepted, the block pulses header_done and classifies the packet:
    - length < 8: malformed. Go to IDLE; drop_count++ and drop_pulse.
    - length == 8: go to IDLE; pkt_count++ if matched, else drop_count++ and drop_pulse. No payload is output.
    - length > 8 and matched: go to FWD.
    - length > 8 and unmatched: go to DROP; drop_count++ and drop_pulse.
  - FWD and DROP each accept length−8 bytes, then return to IDLE.
- Port match: the lowest index i with port_en[i] && target_ports[i] == dst_port wins. Table inputs are sampled at header end only.
- Checksum (CSUM_EN=1):
  - 16-bit ones'-complement accumulation of pseudo_sum plus all UDP bytes, paired big-endian; an odd final byte is padded with 0x00.
  - The packet passes if the folded sum == 16'hFFFF, or if the header checksum field == 0.
  - payload_err = 1 on the payload_last beat if the packet fails. The accumulator includes the last byte in the same cycle.
- pkt_count increments on the payload_last handshake of a forwarded packet.
- Counters wrap modulo 2^CNT_W.
- Cycle counter: starts at 1 on the byte-0 accept and increments every clock. On the packet's final accepted byte (header end for length ≤ 8, last payload/drop byte otherwise), its value is latched into latched_cycle_count. It saturates at all-ones.

## Timing
- ready_out:
  - 1 in IDLE, HDR and DROP.
  - In FWD, ready_out = !payload_valid_out || ready_in, a single registered output stage.
- Payload latency is 1 cycle: a byte accepted in cycle n appears on payload_data_out in cycle n+1.
- Output data, payload_last, payload_chan and payload_err hold while payload_valid_out && !ready_in.
- header_done and drop_pulse assert in the cycle after the byte-7 accept. Header fields update in that same cycle.
- Simultaneous output handshake and input accept in FWD is full throughput: 1 byte/cycle.
- The block accepts byte 0 of the next packet in the cycle after the previous packet's final accept. The registered last payload byte may still be pending at that point.
- Reset: all outputs and counters go to 0, the FSM goes to IDLE, and any in-flight packet and pending output are discarded. The first accepted byte after rst deasserts is byte 0.

## Test plan
- Targets {80, 53, 5000, 53}, all enabled; packet dst=53, length=12, payload AA BB CC DD, correct checksum → 4 beats, payload_chan=1, payload_last on DD, payload_err=0, pkt_count=1.
- Same packet with ready_in toggling 1,0,0,1,… → bytes unchanged and in order, none duplicated; ready_out low while the output is stalled.
- dst=9999, length=10 → drop_pulse once, no payload_valid_out, 10 bytes accepted in total, drop_count=1. A following valid packet forwards normally back-to-back.
- length=5 → malformed drop after 8 bytes; length=8 with dst=80 → header_done, no payload, pkt_count++.
- Checksum field corrupted (nonzero) → payload_err=1 on the last beat only; checksum field 0x0000 → payload_err=0.
- rst asserted after 2 payload bytes → all outputs 0 immediately; the next packet parses correctly from byte 0. Also check latched_cycle_count=12 for an unstalled 12-byte packet.

Source files
------------

// File: rtl/udp_multiport_parser_if.sv
// ----------------------------------------------------------------------------
// udp_multiport_parser_if
// Byte-stream handshake bundle for the UDP multiport parser.
//   Input stream  : data_in, data_valid_in (to parser), ready_out (from parser)
//   Output stream : payload_data_out, payload_valid_out, payload_last,
//                   payload_chan, payload_err (from parser), ready_in (to parser)
// Modports:
//   master - the environment: drives the input stream and downstream ready
//   slave  - the parser: consumes the input stream, drives the payload stream
// ----------------------------------------------------------------------------
interface udp_multiport_parser_if #(
   parameter int CHAN_W = 2
);
   logic [7:0]        data_in;
   logic              data_valid_in;
   logic              ready_out;
   logic [7:0]        payload_data_out;
   logic              payload_valid_out;
   logic              payload_last;
   logic [CHAN_W-1:0] payload_chan;
   logic              payload_err;
   logic              ready_in;

   modport master (
      output data_in, data_valid_in, ready_in,
      input  ready_out, payload_data_out, payload_valid_out,
             payload_last, payload_chan, payload_err
   );

   modport slave (
      input  data_in, data_valid_in, ready_in,
      output ready_out, payload_data_out, payload_valid_out,
             payload_last, payload_chan, payload_err
   );
endinterface

// File: rtl/udp_multiport_parser.sv
// ----------------------------------------------------------------------------
// udp_multiport_parser
// Parses a UDP byte stream (8-byte big-endian header followed by payload),
// matches the destination port against a table of enabled target ports,
// forwards matching payloads tagged with the winning table index, discards
// unmatched or malformed packets, optionally verifies the UDP checksum and
// keeps packet/drop statistics plus the duration of the last packet.
//
// Ports:
//   clk, rst             clock, asynchronous active-high reset
//   target_ports         NUM_PORTS x 16-bit port table, entry i at [16i+15:16i]
//   port_en              per-entry enable
//   pseudo_sum           IP pseudo-header ones'-complement sum (taken at byte 0)
//   bus (slave)          input byte stream and registered payload stream
//   src_port, dst_port,
//   length               header fields, updated the cycle after header end
//   header_done          one-cycle pulse after the 8th header byte
//   drop_pulse           one-cycle pulse when a packet is classified as dropped
//   pkt_count,
//   drop_count           forwarded / dropped packet totals (wrapping)
//   latched_cycle_count  duration in cycles of the last completed packet
// ----------------------------------------------------------------------------
module udp_multiport_parser #(
   parameter int NUM_PORTS = 4,
   parameter int CNT_W     = 16,
   parameter bit CSUM_EN   = 1'b1,
   localparam int CHAN_W   = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic [NUM_PORTS*16-1:0] target_ports,
   input  logic [NUM_PORTS-1:0]   port_en,
   input  logic [15:0]            pseudo_sum,
   udp_multiport_parser_if.slave  bus,
   output logic [15:0]            src_port,
   output logic [15:0]            dst_port,
   output logic [15:0]            length,
   output logic                   header_done,
   output logic                   drop_pulse,
   output logic [CNT_W-1:0]       pkt_count,
   output logic [CNT_W-1:0]       drop_count,
   output logic [CNT_W-1:0]       latched_cycle_count
);

   typedef enum logic [1:0] {IDLE, HDR, FWD, DROP} state_t;

   // 16-bit ones'-complement addition with end-around carry.
   function automatic logic [15:0] ones_add(input logic [15:0] a, input logic [15:0] b);
      logic [16:0] s;
      s = {1'b0, a} + {1'b0, b};
      return s[15:0] + {15'd0, s[16]};
   endfunction

   // Increment that sticks at all-ones.
   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
      return (&v) ? v : v + CNT_W'(1);
   endfunction

   state_t            state, state_nxt;
   logic              ready_int;
   logic              accept;
   logic [2:0]        hdr_idx;
   logic [15:0]       hdr_src, hdr_dst, hdr_len, hdr_csum;
   logic [15:0]       rem;
   logic [CHAN_W-1:0] chan_q;
   logic [15:0]       acc;
   logic              par;
   logic              par_eff;
   logic [15:0]       csum_word;
   logic [15:0]       acc_nxt;
   logic              err_last;
   logic [CNT_W-1:0]  cyc;
   logic              match_hit;
   logic [CHAN_W-1:0] match_idx;
   logic              hdr_end;
   logic              hdr_pkt;
   logic              drop_now;
   logic              body_acc;
   logic              body_last;
   logic              fwd_acc;
   logic              pkt_final;
   logic              last_hs;

   // stage p1: registered payload output
   logic [7:0]        data_p1;
   logic              vld_p1;
   logic              last_p1;
   logic [CHAN_W-1:0] chan_p1;
   logic              err_p1;

   // In FWD the input only advances when the single output register can move.
   assign ready_int = (state == FWD) ? (!vld_p1 || bus.ready_in) : 1'b1;
   assign bus.ready_out = ready_int && !rst;
   assign accept = bus.data_valid_in && ready_int && !rst;

   assign hdr_end   = (state == HDR) && accept && (hdr_idx == 3'd7);
   assign hdr_pkt   = hdr_end && (hdr_len == 16'd8) && match_hit;
   assign drop_now  = hdr_end && ((hdr_len < 16'd8) || !match_hit);
   assign body_acc  = ((state == FWD) || (state == DROP)) && accept;
   assign body_last = body_acc && (rem == 16'd1);
   assign fwd_acc   = (state == FWD) && accept;
   assign pkt_final = (hdr_end && (hdr_len <= 16'd8)) || body_last;
   assign last_hs   = vld_p1 && last_p1 && bus.ready_in;

   // Byte position parity drives big-endian pairing: even bytes are the high
   // half of a word, odd bytes the low half. Adding each byte separately is
   // equivalent to adding whole words, and an odd tail byte is naturally
   // padded with 0x00.
   assign par_eff   = (state == IDLE) ? 1'b0 : par;
   assign csum_word = par_eff ? {8'h00, bus.data_in} : {bus.data_in, 8'h00};
   assign acc_nxt   = ones_add((state == IDLE) ? pseudo_sum : acc, csum_word);
   assign err_last  = CSUM_EN && (hdr_csum != 16'h0000) && (acc_nxt != 16'hFFFF);

   // Lowest enabled matching entry wins: scan downward so the last hit kept
   // is the smallest index.
   always_comb begin
      match_hit = 1'b0;
      match_idx = '0;
      for (int i = NUM_PORTS - 1; i >= 0; i--) begin
         if (port_en[i] && (target_ports[16*i +: 16] == hdr_dst)) begin
            match_hit = 1'b1;
            match_idx = CHAN_W'(i);
         end
      end
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE: if (accept) state_nxt = HDR;
         HDR: begin
            if (hdr_end) begin
               if (hdr_len <= 16'd8) state_nxt = IDLE;
               else if (match_hit)   state_nxt = FWD;
               else                  state_nxt = DROP;
            end
         end
         FWD:     if (body_last) state_nxt = IDLE;
         DROP:    if (body_last) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   // stage p0: header capture, checksum accumulation, payload countdown
   always_ff @(posedge clk) begin
      if (accept) begin
         acc <= acc_nxt;
         par <= !par_eff;
         if (state == IDLE) begin
            hdr_src[15:8] <= bus.data_in;
         end else if (state == HDR) begin
            case (hdr_idx)
               3'd1:    hdr_src[7:0]   <= bus.data_in;
               3'd2:    hdr_dst[15:8]  <= bus.data_in;
               3'd3:    hdr_dst[7:0]   <= bus.data_in;
               3'd4:    hdr_len[15:8]  <= bus.data_in;
               3'd5:    hdr_len[7:0]   <= bus.data_in;
               3'd6:    hdr_csum[15:8] <= bus.data_in;
               3'd7:    hdr_csum[7:0]  <= bus.data_in;
               default: hdr_src[15:8]  <= hdr_src[15:8];
            endcase
         end
      end
      if (hdr_end) begin
         rem    <= hdr_len - 16'd8;
         chan_q <= match_idx;
      end else if (body_acc) begin
         rem <= rem - 16'd1;
      end
      // The byte-0 cycle counts as cycle 1 of the packet.
      if ((state == IDLE) && accept) cyc <= CNT_W'(1);
      else                           cyc <= sat_inc(cyc);
   end

   // Header byte index, pulses, header fields and statistics.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         hdr_idx             <= 3'd0;
         header_done         <= 1'b0;
         drop_pulse          <= 1'b0;
         src_port            <= 16'd0;
         dst_port            <= 16'd0;
         length              <= 16'd0;
         pkt_count           <= '0;
         drop_count          <= '0;
         latched_cycle_count <= '0;
      end else begin
         if ((state == IDLE) && accept)     hdr_idx <= 3'd1;
         else if ((state == HDR) && accept) hdr_idx <= hdr_idx + 3'd1;
         header_done <= hdr_end;
         drop_pulse  <= drop_now;
         if (hdr_end) begin
            src_port <= hdr_src;
            dst_port <= hdr_dst;
            length   <= hdr_len;
         end
         // A header-only hit and the previous packet's last handshake can
         // land on the same edge, so both increments are summed.
         pkt_count <= pkt_count + CNT_W'(last_hs) + CNT_W'(hdr_pkt);
         if (drop_now) drop_count <= drop_count + CNT_W'(1);
         if (pkt_final) latched_cycle_count <= sat_inc(cyc);
      end
   end

   // stage p1: output register, holds while stalled downstream
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         data_p1 <= 8'd0;
         vld_p1  <= 1'b0;
         last_p1 <= 1'b0;
         chan_p1 <= '0;
         err_p1  <= 1'b0;
      end else if (fwd_acc) begin
         data_p1 <= bus.data_in;
         vld_p1  <= 1'b1;
         last_p1 <= (rem == 16'd1);
         chan_p1 <= chan_q;
         err_p1  <= (rem == 16'd1) && err_last;
      end else if (bus.ready_in) begin
         vld_p1 <= 1'b0;
      end
   end

   assign bus.payload_data_out  = data_p1;
   assign bus.payload_valid_out = vld_p1;
   assign bus.payload_last      = last_p1;
   assign bus.payload_chan      = chan_p1;
   assign bus.payload_err       = err_p1;

endmodule

// File: tb/tb_udp_multiport_parser.sv
module tb_udp_multiport_parser;
   localparam int CHAN_W = 2;

   logic        clk = 1'b0;
   logic        rst;
   logic [63:0] target_ports;
   logic [3:0]  port_en;
   logic [15:0] pseudo_sum;
   logic [15:0] src_port, dst_port, length;
   logic        header_done, drop_pulse;
   logic [15:0] pkt_count, drop_count, latched_cycle_count;

   udp_multiport_parser_if #(.CHAN_W(CHAN_W)) bus ();

   udp_multiport_parser #(.NUM_PORTS(4), .CNT_W(16), .CSUM_EN(1'b1)) dut (
      .clk                 (clk),
      .rst                 (rst),
      .target_ports        (target_ports),
      .port_en             (port_en),
      .pseudo_sum          (pseudo_sum),
      .bus                 (bus),
      .src_port            (src_port),
      .dst_port            (dst_port),
      .length              (length),
      .header_done         (header_done),
      .drop_pulse          (drop_pulse),
      .pkt_count           (pkt_count),
      .drop_count          (drop_count),
      .latched_cycle_count (latched_cycle_count)
   );

   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_bad = 0;

   // Observation of the DUT boundary, written only by this block.
   logic [7:0]        q_data[$];
   bit                q_last[$];
   bit                q_err[$];
   logic [CHAN_W-1:0] q_chan[$];
   int n_acc = 0, n_hd = 0, n_drop = 0, n_stall = 0, n_bad_rdy = 0;

   always @(posedge clk) begin
      if (!rst) begin
         if (bus.data_valid_in && bus.ready_out) n_acc++;
         if (header_done) n_hd++;
         if (drop_pulse) n_drop++;
         if (bus.payload_valid_out && !bus.ready_in) begin
            n_stall++;
            if (!bus.payload_last && bus.ready_out) n_bad_rdy++;
         end
         if (bus.payload_valid_out && bus.ready_in) begin
            q_data.push_back(bus.payload_data_out);
            q_last.push_back(bus.payload_last);
            q_err.push_back(bus.payload_err);
            q_chan.push_back(bus.payload_chan);
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "time limit");
   end

   int b_acc, b_hd, b_drop, b_stall, b_bad_rdy, b_q;
   bit tog_en = 1'b0;
   int tog_i  = 0;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
      end
   endtask

   task automatic mark();
      b_acc = n_acc; b_hd = n_hd; b_drop = n_drop;
      b_stall = n_stall; b_bad_rdy = n_bad_rdy; b_q = q_data.size();
   endtask

   task automatic tick();
      @(negedge clk);
      if (tog_en) begin
         bus.ready_in = ((tog_i % 3) == 0);
         tog_i++;
      end
      #1;
   endtask

   task automatic send_byte(input logic [7:0] b);
      int guard;
      tick();
      bus.data_in = b;
      bus.data_valid_in = 1'b1;
      #1;
      guard = 0;
      while (!bus.ready_out && guard < 50) begin
         tick();
         guard++;
      end
      if (guard >= 50) begin
         n_cmp++;
         n_bad++;
         $error("FAIL accept_wait: observed ready_out low for %0d cycles, expected acceptance", guard);
      end
      @(posedge clk);
   endtask

   task automatic send_hdr(input logic [15:0] s, input logic [15:0] d,
                           input logic [15:0] l, input logic [15:0] c);
      send_byte(s[15:8]); send_byte(s[7:0]);
      send_byte(d[15:8]); send_byte(d[7:0]);
      send_byte(l[15:8]); send_byte(l[7:0]);
      send_byte(c[15:8]); send_byte(c[7:0]);
   endtask

   task automatic send_body(input logic [63:0] p, input int n);
      for (int i = n - 1; i >= 0; i--) send_byte(p[8*i +: 8]);
   endtask

   task automatic idle(input int n);
      tick();
      bus.data_valid_in = 1'b0;
      repeat (n) tick();
   endtask

   task automatic chk_payload(input string tag, input int exp_n, input logic [63:0] exp_bytes,
                              input logic [CHAN_W-1:0] exp_chan,
                              input logic [7:0] exp_last, input logic [7:0] exp_err);
      logic [63:0] got;
      logic [7:0]  lm, em;
      bit          chan_ok;
      int          n;
      got = '0; lm = '0; em = '0; chan_ok = 1'b1;
      n = q_data.size() - b_q;
      chk({tag, "_beats"}, 64'(n), 64'(exp_n));
      for (int i = 0; i < n && i < 8; i++) begin
         got = {got[55:0], q_data[b_q + i]};
         lm  = {lm[6:0], q_last[b_q + i]};
         em  = {em[6:0], q_err[b_q + i]};
         if (q_chan[b_q + i] !== exp_chan) chan_ok = 1'b0;
      end
      chk({tag, "_data"}, got, exp_bytes);
      chk({tag, "_last"}, 64'(lm), 64'(exp_last));
      chk({tag, "_err"}, 64'(em), 64'(exp_err));
      if (n > 0) chk({tag, "_chan"}, 64'(chan_ok), 64'd1);
   endtask

   initial begin
      rst = 1'b1;
      target_ports = {16'd53, 16'd5000, 16'd53, 16'd80};
      port_en = 4'b1111;
      pseudo_sum = 16'h1000;
      bus.data_in = 8'h00;
      bus.data_valid_in = 1'b0;
      bus.ready_in = 1'b1;

      // reset state
      repeat (3) @(negedge clk);
      #1;
      chk("rst_ready_out", 64'(bus.ready_out), 64'd0);
      chk("rst_valid", 64'(bus.payload_valid_out), 64'd0);
      chk("rst_pkt_count", 64'(pkt_count), 64'd0);
      chk("rst_latched", 64'(latched_cycle_count), 64'd0);
      rst = 1'b0;
      #1;
      chk("idle_ready_out", 64'(bus.ready_out), 64'd1);

      // matched packet, dst 53 -> entry 1, correct checksum 0x7353
      mark();
      send_hdr(16'h04D2, 16'd53, 16'd12, 16'h7353);
      send_body(64'hAABBCCDD, 4);
      idle(4);
      chk_payload("t1", 4, 64'hAABBCCDD, 2'd1, 8'h01, 8'h00);
      chk("t1_pkt_count", 64'(pkt_count), 64'd1);
      chk("t1_drop_count", 64'(drop_count), 64'd0);
      chk("t1_src", 64'(src_port), 64'h04D2);
      chk("t1_dst", 64'(dst_port), 64'd53);
      chk("t1_len", 64'(length), 64'd12);
      chk("t1_hdr_done", 64'(n_hd - b_hd), 64'd1);
      chk("t1_cycles", 64'(latched_cycle_count), 64'd12);

      // same packet with downstream ready toggling 1,0,0,...
      mark();
      tog_i = 0;
      tog_en = 1'b1;
      send_hdr(16'h04D2, 16'd53, 16'd12, 16'h7353);
      send_body(64'hAABBCCDD, 4);
      idle(6);
      tog_en = 1'b0;
      bus.ready_in = 1'b1;
      chk_payload("t2", 4, 64'hAABBCCDD, 2'd1, 8'h01, 8'h00);
      chk("t2_stall_seen", 64'(n_stall > b_stall), 64'd1);
      chk("t2_ready_while_stalled", 64'(n_bad_rdy - b_bad_rdy), 64'd0);
      chk("t2_pkt_count", 64'(pkt_count), 64'd2);

      // unmatched dst 9999 length 10, then a valid packet back-to-back
      mark();
      send_hdr(16'h1111, 16'd9999, 16'd10, 16'h0000);
      send_body(64'h1122, 2);
      send_hdr(16'h04D2, 16'd53, 16'd12, 16'h7353);
      send_body(64'hAABBCCDD, 4);
      idle(4);
      chk("t3_drop_pulse", 64'(n_drop - b_drop), 64'd1);
      chk("t3_drop_count", 64'(drop_count), 64'd1);
      chk("t3_accepted", 64'(n_acc - b_acc), 64'd22);
      chk_payload("t3", 4, 64'hAABBCCDD, 2'd1, 8'h01, 8'h00);
      chk("t3_pkt_count", 64'(pkt_count), 64'd3);

      // malformed length 5
      mark();
      send_hdr(16'h0001, 16'd80, 16'd5, 16'h0000);
      idle(3);
      chk("t4_drop_count", 64'(drop_count), 64'd2);
      chk("t4_drop_pulse", 64'(n_drop - b_drop), 64'd1);
      chk("t4_hdr_done", 64'(n_hd - b_hd), 64'd1);
      chk("t4_beats", 64'(q_data.size() - b_q), 64'd0);
      chk("t4_len", 64'(length), 64'd5);
      chk("t4_cycles", 64'(latched_cycle_count), 64'd8);

      // header-only packet, dst 80 -> entry 0
      mark();
      send_hdr(16'h0002, 16'd80, 16'd8, 16'h0000);
      idle(3);
      chk("t5_pkt_count", 64'(pkt_count), 64'd4);
      chk("t5_hdr_done", 64'(n_hd - b_hd), 64'd1);
      chk("t5_drop_pulse", 64'(n_drop - b_drop), 64'd0);
      chk("t5_beats", 64'(q_data.size() - b_q), 64'd0);
      chk("t5_dst", 64'(dst_port), 64'd80);

      // corrupted checksum field: error on the last beat only
      mark();
      send_hdr(16'h04D2, 16'd53, 16'd12, 16'h7354);
      send_body(64'hAABBCCDD, 4);
      idle(4);
      chk_payload("t6", 4, 64'hAABBCCDD, 2'd1, 8'h01, 8'h01);
      chk("t6_pkt_count", 64'(pkt_count), 64'd5);

      // checksum field zero: verification skipped
      mark();
      send_hdr(16'h04D2, 16'd53, 16'd12, 16'h0000);
      send_body(64'hAABBCCDD, 4);
      idle(4);
      chk_payload("t7", 4, 64'hAABBCCDD, 2'd1, 8'h01, 8'h00);
      chk("t7_pkt_count", 64'(pkt_count), 64'd6);

      // reset in the middle of a payload
      send_hdr(16'h04D2, 16'd53, 16'd12, 16'h7353);
      send_body(64'hAABB, 2);
      tick();
      rst = 1'b1;
      bus.data_valid_in = 1'b0;
      #1;
      chk("t8_valid", 64'(bus.payload_valid_out), 64'd0);
      chk("t8_ready_out", 64'(bus.ready_out), 64'd0);
      chk("t8_pkt_count", 64'(pkt_count), 64'd0);
      chk("t8_drop_count", 64'(drop_count), 64'd0);
      chk("t8_src", 64'(src_port), 64'd0);
      chk("t8_latched", 64'(latched_cycle_count), 64'd0);
      tick();
      tick();
      rst = 1'b0;
      mark();
      send_hdr(16'h04D2, 16'd53, 16'd12, 16'h7353);
      send_body(64'hAABBCCDD, 4);
      idle(4);
      chk_payload("t9", 4, 64'hAABBCCDD, 2'd1, 8'h01, 8'h00);
      chk("t9_pkt_count", 64'(pkt_count), 64'd1);
      chk("t9_cycles", 64'(latched_cycle_count), 64'd12);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
